// File: rtl/corevx_mem_responder_if.sv
// Avalon-MM bus bundle between a cache-side master and the memory responder.
interface corevx_mem_responder_if;
    logic [33:0] address;
    logic [4:0]  burstcount;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [1:0]  response;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid, response
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid, response
    );
endinterface

// File: rtl/corevx_mem_responder.sv
// Avalon-MM backing memory: configurable read latency, incrementing bursts,
// byte-enabled writes, PMA/range error injection, backdoor preload and beat counters.
//
// state    | meaning
// IDLE     | accepting a read or write command
// RD_LAT   | read accepted, counting down the read latency
// RD_BURST | returning read beats, one per (1+BEAT_GAP) cycles
// WR_BURST | accepting remaining write beats of a burst
module corevx_mem_responder #(
    parameter int DEPTH_WORDS  = 32768,
    parameter int READ_LATENCY = 1,
    parameter int MAX_BURST    = 16,
    parameter int BEAT_GAP     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    corevx_mem_responder_if.slave          m,
    input  logic [33:0]                    pma_lo,
    input  logic [33:0]                    pma_hi,
    input  logic                           bd_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] bd_addr,
    input  logic [31:0]                    bd_wdata,
    output logic [31:0]                    rd_beats,
    output logic [31:0]                    wr_beats,
    output logic                           proto_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [34:0] MEM_BYTES = 35'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, RD_LAT, RD_BURST, WR_BURST} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH_WORDS];
    logic [33:0] cur_addr;
    logic [4:0]  beats_left;
    logic [7:0]  lat_cnt;
    logic [7:0]  gap_cnt;
    logic        force_err;

    logic [33:0]   beat_addr;
    logic [AW-1:0] beat_idx;
    logic [1:0]    beat_resp;
    logic [1:0]    beat_err;
    logic [31:0]   beat_data;
    logic [4:0]    eff_count;
    logic [4:0]    rd_count;
    logic          oversize;
    logic          pma_hit;
    logic          force_eff;
    logic          emit;
    logic          wr_accept;
    logic          wr_en;

    assign m.waitrequest = !rst_n || state == RD_LAT || state == RD_BURST;

    always_comb begin
        beat_addr = (state == IDLE) ? m.address : cur_addr;
        beat_idx  = beat_addr[AW+1:2];
        eff_count = (m.burstcount == 5'd0) ? 5'd1 : m.burstcount;
        oversize  = m.burstcount > 5'(MAX_BURST);
        rd_count  = oversize ? 5'd1 : eff_count;
        pma_hit   = (pma_lo <= pma_hi) && (beat_addr >= pma_lo) && (beat_addr <= pma_hi);
        if (beat_addr[1:0] != 2'b00)
            beat_resp = 2'b10;
        else if (({1'b0, beat_addr} >= MEM_BYTES) || pma_hit)
            beat_resp = 2'b11;
        else
            beat_resp = 2'b00;
        // an oversized read returns a single SLAVEERROR beat regardless of address
        force_eff = (state == IDLE) ? oversize : force_err;
        beat_err  = force_eff ? 2'b10 : beat_resp;
        beat_data = (beat_err == 2'b00) ? mem[beat_idx] : 32'h0;
        emit      = (state == IDLE && m.read && READ_LATENCY == 1) ||
                    (state == RD_LAT && lat_cnt == 8'd1) ||
                    (state == RD_BURST && beats_left != 5'd0 && gap_cnt == 8'd0);
        wr_accept = rst_n && m.write &&
                    ((state == IDLE && !m.read) || state == WR_BURST);
        wr_en     = wr_accept && beat_resp == 2'b00 && !(state == IDLE && oversize);
    end

    // backdoor write lands last so it wins over a bus write to the same word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (m.byteenable[b]) mem[beat_idx][8*b +: 8] <= m.writedata[8*b +: 8];
            end
        end
        if (bd_we) mem[bd_addr] <= bd_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            m.readdatavalid <= 1'b0;
            m.readdata      <= 32'h0;
            m.response      <= 2'b00;
            rd_beats        <= 32'h0;
            wr_beats        <= 32'h0;
            proto_err       <= 1'b0;
            cur_addr        <= 34'h0;
            beats_left      <= 5'd0;
            lat_cnt         <= 8'd0;
            gap_cnt         <= 8'd0;
            force_err       <= 1'b0;
        end else begin
            m.readdatavalid <= 1'b0;
            if (wr_accept) wr_beats <= wr_beats + 32'd1;
            case (state)
                IDLE: begin
                    if (m.read) begin
                        proto_err <= proto_err | m.write | oversize;
                        force_err <= oversize;
                        cur_addr  <= m.address;
                        if (READ_LATENCY == 1) begin
                            beats_left <= rd_count - 5'd1;
                            state      <= RD_BURST;
                        end else begin
                            beats_left <= rd_count;
                            lat_cnt    <= 8'(READ_LATENCY - 1);
                            state      <= RD_LAT;
                        end
                    end else if (m.write) begin
                        proto_err <= proto_err | oversize;
                        if (!oversize && eff_count > 5'd1) begin
                            beats_left <= eff_count - 5'd1;
                            cur_addr   <= m.address + 34'd4;
                            state      <= WR_BURST;
                        end
                    end
                end
                RD_LAT: begin
                    if (lat_cnt == 8'd1) begin
                        beats_left <= beats_left - 5'd1;
                        state      <= RD_BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                RD_BURST: begin
                    if (beats_left == 5'd0)
                        state <= IDLE;
                    else if (gap_cnt != 8'd0)
                        gap_cnt <= gap_cnt - 8'd1;
                    else
                        beats_left <= beats_left - 5'd1;
                end
                WR_BURST: begin
                    if (m.read) proto_err <= 1'b1;
                    if (m.write) begin
                        cur_addr   <= cur_addr + 34'd4;
                        beats_left <= beats_left - 5'd1;
                        if (beats_left == 5'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (emit) begin
                m.readdatavalid <= 1'b1;
                m.readdata      <= beat_data;
                m.response      <= beat_err;
                rd_beats        <= rd_beats + 32'd1;
                cur_addr        <= beat_addr + 34'd4;
                gap_cnt         <= 8'(BEAT_GAP);
            end
        end
    end
endmodule

// File: tb/tb_corevx_mem_responder.sv
// Directed bench for corevx_mem_responder: one instance at read latency 1, one at latency 3.
module tb_corevx_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] pma_lo = 34'h1;
    logic [33:0] pma_hi = 34'h0;
    logic        bd_we = 1'b0;
    logic [9:0]  bd_addr = 10'h0;
    logic [31:0] bd_wdata = 32'h0;
    logic [31:0] rd_beats1, wr_beats1, rd_beats3, wr_beats3;
    logic        proto_err1, proto_err3;

    int n_vec = 0;
    int n_err = 0;

    corevx_mem_responder_if if1();
    corevx_mem_responder_if if3();

    corevx_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .MAX_BURST(16), .BEAT_GAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .m(if1),
        .pma_lo(pma_lo), .pma_hi(pma_hi),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .rd_beats(rd_beats1), .wr_beats(wr_beats1), .proto_err(proto_err1)
    );

    corevx_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .MAX_BURST(16), .BEAT_GAP(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .m(if3),
        .pma_lo(pma_lo), .pma_hi(pma_hi),
        .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .rd_beats(rd_beats3), .wr_beats(wr_beats3), .proto_err(proto_err3)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_load(input logic [9:0] idx, input logic [31:0] data);
        bd_we = 1'b1; bd_addr = idx; bd_wdata = data;
        step();
        bd_we = 1'b0;
    endtask

    task automatic start_rd1(input logic [33:0] addr, input logic [4:0] bc);
        if1.address = addr; if1.burstcount = bc; if1.read = 1'b1;
        step();
        if1.read = 1'b0;
    endtask

    task automatic beat1(input string tag, input logic [31:0] data, input logic [1:0] resp);
        check_val({tag, "_valid"}, 64'(if1.readdatavalid), 64'd1);
        check_val({tag, "_data"}, 64'(if1.readdata), 64'(data));
        check_val({tag, "_resp"}, 64'(if1.response), 64'(resp));
    endtask

    task automatic wr1(input logic [33:0] addr, input logic [4:0] bc, input logic [31:0] data, input logic [3:0] be);
        if1.address = addr; if1.burstcount = bc; if1.write = 1'b1;
        if1.writedata = data; if1.byteenable = be;
        step();
        if1.write = 1'b0;
    endtask

    initial begin
        if1.address = '0; if1.burstcount = '0; if1.read = 1'b0; if1.write = 1'b0;
        if1.writedata = '0; if1.byteenable = '0;
        if3.address = '0; if3.burstcount = '0; if3.read = 1'b0; if3.write = 1'b0;
        if3.writedata = '0; if3.byteenable = '0;

        step(); step();
        check_val("rst_wait", 64'(if1.waitrequest), 64'd1);
        check_val("rst_rdv", 64'(if1.readdatavalid), 64'd0);
        check_val("rst_rdbeats", 64'(rd_beats1), 64'd0);
        check_val("rst_proto", 64'(proto_err1), 64'd0);
        rst_n = 1'b1;
        #1;
        check_val("idle_wait", 64'(if1.waitrequest), 64'd0);

        bd_load(10'd0, 32'hBEAFDEAD);
        bd_load(10'd4, 32'd1);
        bd_load(10'd5, 32'd2);
        bd_load(10'd6, 32'd3);
        bd_load(10'd7, 32'd4);
        bd_load(10'd16, 32'h0);
        bd_load(10'd17, 32'h0);
        bd_load(10'd20, 32'h0);
        bd_load(10'd63, 32'h12345678);
        bd_load(10'd64, 32'h5A5A5A5A);

        // single read, latency 1
        start_rd1(34'h0, 5'd1);
        beat1("rd0", 32'hBEAFDEAD, 2'b00);
        check_val("rd0_wait", 64'(if1.waitrequest), 64'd1);
        check_val("rd0_cnt", 64'(rd_beats1), 64'd1);
        step();
        check_val("rd0_done_rdv", 64'(if1.readdatavalid), 64'd0);
        check_val("rd0_done_wait", 64'(if1.waitrequest), 64'd0);

        // latency-3 burst of four
        if3.address = 34'h10; if3.burstcount = 5'd4; if3.read = 1'b1;
        step();
        if3.read = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check_val($sformatf("l3_wait_c%0d", c), 64'(if3.waitrequest), (c < 6) ? 64'd1 : 64'd0);
            check_val($sformatf("l3_rdv_c%0d", c), 64'(if3.readdatavalid), (c >= 2 && c <= 5) ? 64'd1 : 64'd0);
            if (c >= 2 && c <= 5) begin
                check_val($sformatf("l3_data_c%0d", c), 64'(if3.readdata), 64'(c - 1));
                check_val($sformatf("l3_resp_c%0d", c), 64'(if3.response), 64'd0);
            end
            step();
        end

        // byte-enabled write burst and readback
        if1.address = 34'h40; if1.burstcount = 5'd2; if1.write = 1'b1;
        if1.writedata = 32'hAABBCCDD; if1.byteenable = 4'b0101;
        step();
        check_val("wr_burst_wait", 64'(if1.waitrequest), 64'd0);
        if1.writedata = 32'h11223344; if1.byteenable = 4'b1111;
        step();
        if1.write = 1'b0;
        check_val("wr_cnt", 64'(wr_beats1), 64'd2);
        start_rd1(34'h40, 5'd2);
        beat1("wrb0", 32'h00BB00DD, 2'b00);
        step();
        beat1("wrb1", 32'h11223344, 2'b00);
        step();
        check_val("wrb_cnt", 64'(rd_beats1), 64'd3);

        // PMA region: mixed burst, dropped write
        pma_lo = 34'h100; pma_hi = 34'h103;
        start_rd1(34'hFC, 5'd2);
        beat1("pma0", 32'h12345678, 2'b00);
        step();
        beat1("pma1", 32'h0, 2'b11);
        step();
        wr1(34'h100, 5'd1, 32'hFFFFFFFF, 4'hF);
        pma_lo = 34'h1; pma_hi = 34'h0;
        start_rd1(34'h100, 5'd1);
        beat1("pma_keep", 32'h5A5A5A5A, 2'b00);
        step();

        // backdoor wins over same-cycle bus write
        bd_we = 1'b1; bd_addr = 10'd20; bd_wdata = 32'hCAFEF00D;
        if1.address = 34'h50; if1.burstcount = 5'd1; if1.write = 1'b1;
        if1.writedata = 32'h0; if1.byteenable = 4'hF;
        step();
        bd_we = 1'b0; if1.write = 1'b0;
        start_rd1(34'h50, 5'd1);
        beat1("bd_prio", 32'hCAFEF00D, 2'b00);
        step();

        // error classes and oversized burst
        start_rd1(34'h2, 5'd1);
        beat1("misalign", 32'h0, 2'b10);
        step();
        check_val("proto_before", 64'(proto_err1), 64'd0);
        start_rd1(34'h0, 5'd20);
        beat1("oversize", 32'h0, 2'b10);
        step();
        check_val("oversize_one_beat", 64'(if1.readdatavalid), 64'd0);
        check_val("oversize_proto", 64'(proto_err1), 64'd1);
        start_rd1(34'h1000, 5'd1);
        beat1("range", 32'h0, 2'b11);
        step();
        check_val("tot_rd", 64'(rd_beats1), 64'd10);
        check_val("tot_wr", 64'(wr_beats1), 64'd4);

        // reset during second beat of a four-beat read
        start_rd1(34'h10, 5'd4);
        beat1("rstb0", 32'd1, 2'b00);
        step();
        beat1("rstb1", 32'd2, 2'b00);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check_val("rst_mid_rdv", 64'(if1.readdatavalid), 64'd0);
        check_val("rst_mid_wait", 64'(if1.waitrequest), 64'd0);
        check_val("rst_mid_rd", 64'(rd_beats1), 64'd0);
        check_val("rst_mid_wr", 64'(wr_beats1), 64'd0);
        check_val("rst_mid_proto", 64'(proto_err1), 64'd0);
        check_val("rst_mid_rd3", 64'(rd_beats3), 64'd0);
        step();
        check_val("rst_after_rdv", 64'(if1.readdatavalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
